aemb2_ifetch_queue: RTL and testbench
=====================================

Name: aemb2_ifetch_queue

Overview:
- Instruction-fetch prefetch queue between the core fetch stage and the instruction port of the dual-port local RAM.
- Acts as Wishbone-style master on the iwb_* bus: issues sequential word reads, captures returned words into a small FIFO, and presents them to the core with a valid/ready handshake.
- Core branch redirects flush the queue and restart fetch at the target address.

Parameters:
- AW, 14, byte-address width of local RAM; word address is AW-1:2.
- DEPTH, 4, queue entries; power of two, at least 2.
- RST_VEC, 0, word address fetched first after reset, width AW-2.

Ports:
- sys_clk_i  in  1  system clock, rising edge.
- sys_rst_i  in  1  system reset, asynchronous, active-low (0 = reset).
- iwb_adr_o  out  AW-2  word address [AW-1:2] to RAM.
- iwb_stb_o  out  1  read strobe.
- iwb_cyc_o  out  1  equals iwb_stb_o.
- iwb_wre_o  out  1  tied 0.
- iwb_sel_o  out  4  tied 4'hF.
- iwb_tag_o  out  1  tied 0.
- iwb_dat_i  in  32  read data, valid when iwb_ack_i=1.
- iwb_ack_i  in  1  RAM acknowledge.
- fet_dat_o  out  32  instruction word at queue head.
- fet_pc_o  out  AW-2  word address of fet_dat_o.
- fet_vld_o  out  1  head entry valid.
- fet_rdy_i  in  1  core accepts head; pop when fet_vld_o & fet_rdy_i.
- br_i  in  1  redirect request, single-cycle pulse.
- br_adr_i  in  AW-2  redirect target word address.

Behaviour:
- Reset (sys_rst_i=0, asynchronous):
  - iwb_stb_o=0, iwb_adr_o=RST_VEC.
  - fet_vld_o=0, fet_dat_o=0, fet_pc_o=0.
  - Queue empty; drop flag clear.
- Bus master states:
  - IDLE: stb=0.
  - REQ: stb=1 and iwb_adr_o held constant until iwb_ack_i.
- The RAM acks one cycle after stb, and never on two consecutive cycles. Any stb held across an ack edge is a new request.
- IDLE->REQ when credit > 0, where credit = DEPTH - count - (REQ ? 1 : 0).
- On ack in REQ:
  - Word pushed with its address; iwb_adr_o increments by 1, wrapping modulo 2^(AW-2).
  - Stay in REQ if credit after push > 0, else go to IDLE.
- Queue:
  - Registered circular buffer; rd/wr pointers wrap at DEPTH.
  - count in 0..DEPTH; push and pop in the same cycle leave count unchanged.
  - A pushed word is visible on fet_* the cycle after the ack edge (1-cycle latency).
  - A push never occurs when full; credit accounting guarantees this.
- Redirect (br_i=1):
  - Queue flushed at that edge; any pop that cycle is ignored.
  - fet_vld_o=0 next cycle.
  - Target latched as the next fetch address.
  - If in REQ without ack this cycle: drop flag set; stb and old address held until ack; that data is discarded; fetch then restarts at the target.
  - If ack coincides with br_i: the acked word is discarded and the next cycle issues the target address.
  - If in IDLE: REQ at the target next cycle.
  - A second br_i while drop is pending overwrites the latched target.
- Asynchronous reset mid-request abandons the request; the RAM ack that may follow is ignored because stb=0.
- fet_dat_o and fet_pc_o hold their values while fet_vld_o=1 and fet_rdy_i=0.

Optional Feature:
- Macro: AEMB2_IFQ_BYPASS_EN.
- Defined:
  - When the queue is empty, drop is clear and iwb_ack_i=1, fet_vld_o=1 in the ack cycle with fet_dat_o=iwb_dat_i and fet_pc_o=iwb_adr_o (combinational fall-through).
  - If fet_rdy_i=1 the word is consumed and not pushed; otherwise it is pushed normally.
  - br_i in the same cycle suppresses fall-through.
- Undefined: fet_* outputs are purely registered from the queue head; latency from ack to valid is always 1 cycle.

Test Plan:
- Release reset, RST_VEC=0x010, fet_rdy_i=1 -> stb rises at the first edge; addresses 0x010, 0x011, 0x012 issued in order; fet_pc_o sequence 0x010, 0x011, 0x012 with matching RAM words; no gaps beyond the RAM ack cadence.
- fet_rdy_i=0, DEPTH=4 -> exactly 4 acks, then stb=0 with count=4; raise fet_rdy_i for 1 cycle -> one pop, then one new request at 0x014.
- br_i with br_adr_i=0x100 while stb outstanding at 0x012 -> word from 0x012 never appears on fet_*; next issued address is 0x100; first valid fet_pc_o=0x100.
- br_i coincident with ack of 0x013 -> 0x013 discarded; fet_vld_o=0 next cycle; next stb address is br_adr_i.
- Word address 2^(AW-2)-1 fetched -> next address 0; fet_pc_o wraps correctly.
- Drive sys_rst_i=0 mid-REQ and hold 2 cycles -> all outputs at reset values immediately; after release, fetch restarts at RST_VEC. With AEMB2_IFQ_BYPASS_EN defined, also confirm fet_vld_o rises in the first ack cycle after an empty queue.

Source files
------------

// File: rtl/aemb2_ifetch_queue.sv
// aemb2_ifetch_queue: instruction prefetch queue mastering the iwb_* RAM port.
// Define AEMB2_IFQ_BYPASS_EN to let an acked word fall through an empty queue in the ack cycle.
module aemb2_ifetch_queue #(
   parameter int              AW      = 14,
   parameter int              DEPTH   = 4,
   parameter logic [AW-3:0]   RST_VEC = '0
) (
   input  logic              sys_clk_i,
   input  logic              sys_rst_i,
   output logic [AW-3:0]     iwb_adr_o,
   output logic              iwb_stb_o,
   output logic              iwb_cyc_o,
   output logic              iwb_wre_o,
   output logic [3:0]        iwb_sel_o,
   output logic              iwb_tag_o,
   input  logic [31:0]       iwb_dat_i,
   input  logic              iwb_ack_i,
   output logic [31:0]       fet_dat_o,
   output logic [AW-3:0]     fet_pc_o,
   output logic              fet_vld_o,
   input  logic              fet_rdy_i,
   input  logic              br_i,
   input  logic [AW-3:0]     br_adr_i
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   typedef enum logic {IDLE, REQ} st_t;

   st_t           st;
   logic [AW-3:0] adr, tgt;
   logic          drop;
   logic [31:0]   q_dat [DEPTH];
   logic [AW-3:0] q_pc  [DEPTH];
   logic [PW-1:0] wp, rp;
   logic [PW:0]   cnt, cnt_n;
   logic          ack, empty, byp, push, pop;

   assign ack   = (st == REQ) & iwb_ack_i;
   assign empty = (cnt == '0);
`ifdef AEMB2_IFQ_BYPASS_EN
   assign byp   = empty & ~drop & ack & ~br_i;
`else
   assign byp   = 1'b0;
`endif
   // a bypassed word taken by the core never enters the queue
   assign push  = ack & ~drop & ~br_i & ~(byp & fet_rdy_i);
   assign pop   = ~empty & fet_rdy_i & ~br_i;
   assign cnt_n = cnt + (PW+1)'(push) - (PW+1)'(pop);

   assign iwb_adr_o = adr;
   assign iwb_stb_o = (st == REQ);
   assign iwb_cyc_o = iwb_stb_o;
   assign iwb_wre_o = 1'b0;
   assign iwb_sel_o = 4'hF;
   assign iwb_tag_o = 1'b0;

   assign fet_vld_o = ~empty | byp;
   assign fet_dat_o = byp ? iwb_dat_i : (empty ? '0 : q_dat[rp]);
   assign fet_pc_o  = byp ? adr : (empty ? '0 : q_pc[rp]);

   always_ff @(posedge sys_clk_i) begin
      if (push) begin
         q_dat[wp] <= iwb_dat_i;
         q_pc[wp]  <= adr;
      end
   end

   always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
      if (!sys_rst_i) begin
         st   <= IDLE;
         adr  <= RST_VEC;
         tgt  <= RST_VEC;
         drop <= 1'b0;
         cnt  <= '0;
         wp   <= '0;
         rp   <= '0;
      end else begin
         cnt <= br_i ? '0 : cnt_n;
         wp  <= br_i ? '0 : wp + PW'(push);
         rp  <= br_i ? '0 : rp + PW'(pop);
         if (br_i) tgt <= br_adr_i;
         if (ack) begin
            drop <= 1'b0;
            adr  <= (br_i | drop) ? (br_i ? br_adr_i : tgt) : adr + 1'b1;
            st   <= (br_i | drop | (cnt_n < FULL)) ? REQ : IDLE;
         end else if (br_i) begin
            // an outstanding read must still complete; its data is dropped on ack
            if (st == REQ) drop <= 1'b1;
            else begin
               adr <= br_adr_i;
               st  <= REQ;
            end
         end else if (st == IDLE && cnt < FULL) begin
            st <= REQ;
         end
      end
   end
endmodule

// File: tb/tb_aemb2_ifetch_queue.sv
// tb_aemb2_ifetch_queue: directed bench with a RAM model and an expected-PC scoreboard.
module tb_aemb2_ifetch_queue;
   localparam int AW = 14;
`ifdef AEMB2_IFQ_BYPASS_EN
   localparam logic BYP = 1'b1;
`else
   localparam logic BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [11:0] iwb_adr;
   logic        stb, cyc, wre, tag;
   logic [3:0]  sel;
   logic [31:0] rdat = '0;
   logic        ack = 1'b0;
   logic [31:0] fdat;
   logic [11:0] fpc;
   logic        fvld;
   logic        rdy = 1'b1;
   logic        br = 1'b0;
   logic [11:0] badr = '0;
   int          total = 0, bad = 0, nack = 0, a0 = 0;
   logic [11:0] expq [$];

   always #5 clk = ~clk;

   aemb2_ifetch_queue #(.AW(AW), .DEPTH(4), .RST_VEC(12'h010)) dut (
      .sys_clk_i(clk), .sys_rst_i(rst_n),
      .iwb_adr_o(iwb_adr), .iwb_stb_o(stb), .iwb_cyc_o(cyc), .iwb_wre_o(wre),
      .iwb_sel_o(sel), .iwb_tag_o(tag), .iwb_dat_i(rdat), .iwb_ack_i(ack),
      .fet_dat_o(fdat), .fet_pc_o(fpc), .fet_vld_o(fvld), .fet_rdy_i(rdy),
      .br_i(br), .br_adr_i(badr)
   );

   function automatic logic [31:0] word(input logic [11:0] a);
      return {8'hA5, a, ~a};
   endfunction

   // RAM: ack one cycle after strobe, never twice in a row
   always @(posedge clk) begin
      if (stb & ack) nack <= nack + 1;
      ack  <= stb & ~ack;
      rdat <= word(iwb_adr);
   end

   task automatic chk(input string t, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: got %h want %h", t, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill(input logic [11:0] base);
      expq.delete();
      for (int i = 0; i < 16; i++) expq.push_back(12'(base + 12'(i)));
   endtask

   always @(negedge clk) begin
      if (rst_n && fvld && rdy && !br) begin
         if (expq.size() == 0) begin
            total++;
            assert (0) else begin
               bad++;
               $error("FAIL unexpected_pc: got %h want none", fpc);
            end
         end else begin
            logic [11:0] e;
            e = expq.pop_front();
            chk("fet_pc", 32'(fpc), 32'(e));
            chk("fet_dat", fdat, word(e));
         end
      end
   end

   initial begin
      repeat (3) tick();
      chk("rst_stb", 32'(stb), 0);
      chk("rst_cyc", 32'(cyc), 0);
      chk("rst_adr", 32'(iwb_adr), 32'h010);
      chk("rst_vld", 32'(fvld), 0);
      chk("rst_dat", fdat, 0);
      chk("rst_pc", 32'(fpc), 0);
      chk("tie_wre", 32'(wre), 0);
      chk("tie_sel", 32'(sel), 32'hF);
      chk("tie_tag", 32'(tag), 0);
      fill(12'h010);
      rst_n = 1'b1;
      tick();
      chk("stb_first", 32'(stb), 1);
      chk("adr_first", 32'(iwb_adr), 32'h010);
      tick();
      chk("ack_cadence", 32'(ack), 1);
      chk("vld_ack_cycle", 32'(fvld), 32'(BYP));
      tick();
      chk("adr_second", 32'(iwb_adr), 32'h011);
      for (int k = 0; k < 40 && !(iwb_adr == 12'h012 && stb && !ack); k++) tick();
      chk("reach_012", 32'(iwb_adr == 12'h012 && stb && !ack), 1);
      // redirect while the read of 0x012 is outstanding
      br = 1'b1; badr = 12'h100;
      tick();
      br = 1'b0;
      fill(12'h100);
      chk("br_vld", 32'(fvld), 0);
      chk("drop_hold_adr", 32'(iwb_adr), 32'h012);
      chk("drop_hold_stb", 32'(stb), 1);
      tick();
      chk("br_target", 32'(iwb_adr), 32'h100);
      for (int k = 0; k < 40 && !(iwb_adr == 12'h102 && ack); k++) tick();
      chk("reach_102_ack", 32'(iwb_adr == 12'h102 && ack), 1);
      // redirect coincident with an ack; also stall the core
      br = 1'b1; badr = 12'h200; rdy = 1'b0;
      tick();
      br = 1'b0;
      a0 = nack;
      fill(12'h200);
      chk("brack_vld", 32'(fvld), 0);
      chk("brack_adr", 32'(iwb_adr), 32'h200);
      chk("brack_stb", 32'(stb), 1);
      repeat (20) tick();
      chk("full_acks", 32'(nack - a0), 4);
      chk("full_stb", 32'(stb), 0);
      chk("full_vld", 32'(fvld), 1);
      chk("full_pc", 32'(fpc), 32'h200);
      tick();
      chk("hold_pc", 32'(fpc), 32'h200);
      chk("hold_dat", fdat, word(12'h200));
      rdy = 1'b1;
      tick();
      rdy = 1'b0;
      chk("pop_still_idle", 32'(stb), 0);
      tick();
      chk("refill_stb", 32'(stb), 1);
      chk("refill_adr", 32'(iwb_adr), 32'h204);
      chk("refill_head", 32'(fpc), 32'h201);
      repeat (6) tick();
      chk("refill_acks", 32'(nack - a0), 5);
      chk("refill_idle", 32'(stb), 0);
      rdy = 1'b1;
      repeat (3) tick();
      // address wrap
      br = 1'b1; badr = 12'hFFE;
      tick();
      br = 1'b0;
      fill(12'hFFE);
      chk("wrap_br_vld", 32'(fvld), 0);
      repeat (20) tick();
      chk("wrap_progress", 32'(expq.size() <= 12), 1);
      // asynchronous reset mid-request
      for (int k = 0; k < 40 && !(stb && !ack); k++) tick();
      chk("reach_req", 32'(stb && !ack), 1);
      rst_n = 1'b0;
      #1;
      chk("arst_stb", 32'(stb), 0);
      chk("arst_adr", 32'(iwb_adr), 32'h010);
      chk("arst_vld", 32'(fvld), 0);
      chk("arst_dat", fdat, 0);
      chk("arst_pc", 32'(fpc), 0);
      fill(12'h010);
      repeat (2) tick();
      chk("arst_hold_stb", 32'(stb), 0);
      rst_n = 1'b1;
      tick();
      chk("restart_stb", 32'(stb), 1);
      chk("restart_adr", 32'(iwb_adr), 32'h010);
      tick();
      chk("restart_ack", 32'(ack), 1);
      chk("restart_vld_ack", 32'(fvld), 32'(BYP));
      repeat (10) tick();
      chk("restart_progress", 32'(expq.size() < 16), 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
